result_merger: RTL and testbench
================================

Name: result_merger

Overview:
- Return-path counterpart of the dual-core instruction dispatcher. It collects completion records from core 1 and core 2 and presents them to the register/memory writeback stage as one stream in original program order.
- Each instruction carries a sequence tag assigned at dispatch. The merger is a tag-indexed reorder buffer with an in-order commit pointer and a registered valid/ready output stage.

Parameters:
- SEQ_W, 4, sequence tag width. Reorder window = 2^SEQ_W slots.
- DATA_W, 32, result data width.
- ADDR_W, 12, destination field width: {mem/reg flag, 11-bit address}, same encoding as instruction bits [22:11].

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- c1_valid  in  1  core 1 completion valid
- c1_ready  out  1  core 1 completion accepted when c1_valid && c1_ready
- c1_seq  in  SEQ_W  core 1 sequence tag
- c1_addr  in  ADDR_W  core 1 destination
- c1_data  in  DATA_W  core 1 result
- c2_valid, c2_ready, c2_seq, c2_addr, c2_data: as core 1, for core 2
- wb_valid  out  1  writeback record valid
- wb_ready  in  1  writeback stage accepts
- wb_seq  out  SEQ_W  committed tag
- wb_addr  out  ADDR_W  committed destination
- wb_data  out  DATA_W  committed result
- occupancy  out  SEQ_W+1  number of filled slots, excluding the output register
- dup_err  out  1  sticky protocol error flag

Behaviour:
- Reset (clk edge with resetn=0):
  - all slot valid bits = 0, head = 0.
  - wb_valid = 0; wb_seq, wb_addr, wb_data = 0.
  - occupancy = 0, dup_err = 0.
  - Reset mid-operation discards all buffered and output-staged records.
- Storage: per slot {valid, addr, data}. Slot index = tag.
- Input acceptance, ready derived combinationally from registered state:
  - c1_ready = !slot_valid[c1_seq].
  - c2_ready = !slot_valid[c2_seq] && !(c1_valid && c1_seq == c2_seq).
  - On handshake, the slot is written and valid is set at that edge.
  - A tag whose slot is still occupied (next-lap alias, window full) stalls that core until the slot commits. This is legal and not an error.
- Simultaneous identical tags (c1_valid && c2_valid && c1_seq == c2_seq):
  - core 1 wins and core 2 is stalled.
  - dup_err set at that edge, held until reset.
- Commit:
  - Fires when slot_valid[head] && (!wb_valid || wb_ready), using pre-edge registered state.
  - Effects: wb_seq/wb_addr/wb_data <= head slot contents; wb_valid <= 1; slot_valid[head] <= 0; head <= head+1 mod 2^SEQ_W.
  - Otherwise, if wb_valid && wb_ready, then wb_valid <= 0.
- Throughput: one commit per cycle while consecutive tags are present and wb_ready=1.
- Latency: handshake at edge N (slot written) -> commit at edge N+1 -> wb_valid high after N+1 (1 cycle). A record written at an edge is never committed at that same edge.
- A slot freed by commit at edge N has its tag's ready high in the following cycle. Write and commit never target the same slot at one edge, because ready is low for the head slot while it is valid.
- Output stability: while wb_valid && !wb_ready, all wb_* hold and head does not advance.
- occupancy(next) = occupancy + accepts (0..2) - commit (0..1). It never exceeds 2^SEQ_W.
- Both cores may be accepted in the same cycle when tags differ and both slots are free.

Test Plan:
- In-order pair: SEQ_W=4; c1 tag0 and c2 tag1 in the same cycle, wb_ready=1 -> wb_seq 0 then 1 on consecutive cycles, data/addr match, occupancy returns to 0.
- Out-of-order: c2 tag2 at cycle 0, c1 tag1 at cycle 1, c1 tag0 at cycle 3 -> wb_valid stays low until cycle 4; wb_seq 0,1,2 at cycles 4,5,6.
- Backpressure: tag0 committed to the output register, wb_ready=0 for 5 cycles while tags 1-3 arrive -> wb_seq=0 and data stable, head=1, occupancy=3; releasing wb_ready gives 0,1,2,3 back-to-back.
- Wrap: SEQ_W=3; 20 tags alternating between cores, random 0-3 cycle delays -> wb_seq 0..7,0..7,0..3 in order with no loss; head wraps 7->0.
- Alias stall: SEQ_W=3; tags 1-7 filled and tag0 missing; c1 presents next-lap tag1 -> c1_ready=0 until tag0 arrives and tag1 commits; accepted the following cycle; dup_err stays 0.
- Duplicate + reset: both cores present tag3 in the same cycle -> c1 stored, c2_ready=0, dup_err=1 persists; then resetn=0 for one edge with records pending -> wb_valid=0, occupancy=0, dup_err=0, head=0.

Source files
------------

// File: rtl/result_merger.sv
// Tag-indexed reorder buffer merging two cores' completion streams back into
// program order, with a registered valid/ready writeback stage.
module result_merger #(
  parameter int SEQ_W  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              c1_valid,
  output logic              c1_ready,
  input  logic [SEQ_W-1:0]  c1_seq,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_data,
  input  logic              c2_valid,
  output logic              c2_ready,
  input  logic [SEQ_W-1:0]  c2_seq,
  input  logic [ADDR_W-1:0] c2_addr,
  input  logic [DATA_W-1:0] c2_data,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [SEQ_W-1:0]  wb_seq,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [SEQ_W:0]    occupancy,
  output logic              dup_err
);
  localparam int DEPTH = 1 << SEQ_W;

  logic [DEPTH-1:0]             r_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic [SEQ_W-1:0]             r_head;
  logic                         r_wb_valid;
  logic [SEQ_W-1:0]             r_wb_seq;
  logic [ADDR_W-1:0]            r_wb_addr;
  logic [DATA_W-1:0]            r_wb_data;
  logic [SEQ_W:0]               r_occ;
  logic                         r_dup;

  logic w_c1_claim, w_acc1, w_acc2, w_commit, w_dup;
  logic [SEQ_W:0] w_occ_nxt;

  // Core 1 has priority on a shared tag, so core 2 yields whenever core 1 claims it.
  assign w_c1_claim = c1_valid && (c1_seq == c2_seq);
  assign c1_ready   = !r_vld[c1_seq];
  assign c2_ready   = !r_vld[c2_seq] && !w_c1_claim;
  assign w_acc1     = c1_valid && c1_ready;
  assign w_acc2     = c2_valid && c2_ready;
  assign w_dup      = w_c1_claim && c2_valid;
  assign w_commit   = r_vld[r_head] && (!r_wb_valid || wb_ready);
  assign w_occ_nxt  = r_occ + (SEQ_W+1)'(w_acc1) + (SEQ_W+1)'(w_acc2)
                    - (SEQ_W+1)'(w_commit);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_vld      <= '0;
      r_head     <= '0;
      r_wb_valid <= 1'b0;
      r_wb_seq   <= '0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_occ      <= '0;
      r_dup      <= 1'b0;
    end else begin
      // Head slot is never writable while valid, so commit-clear and fill
      // cannot collide on the same slot.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_commit && r_head == SEQ_W'(i)) r_vld[i] <= 1'b0;
        if (w_acc1 && c1_seq == SEQ_W'(i)) begin
          r_vld[i]  <= 1'b1;
          r_addr[i] <= c1_addr;
          r_data[i] <= c1_data;
        end
        if (w_acc2 && c2_seq == SEQ_W'(i)) begin
          r_vld[i]  <= 1'b1;
          r_addr[i] <= c2_addr;
          r_data[i] <= c2_data;
        end
      end
      if (w_commit) begin
        r_wb_valid <= 1'b1;
        r_wb_seq   <= r_head;
        r_wb_addr  <= r_addr[r_head];
        r_wb_data  <= r_data[r_head];
        r_head     <= r_head + SEQ_W'(1);
      end else if (r_wb_valid && wb_ready) begin
        r_wb_valid <= 1'b0;
      end
      r_occ <= w_occ_nxt;
      if (w_dup) r_dup <= 1'b1;
    end
  end

  assign wb_valid  = r_wb_valid;
  assign wb_seq    = r_wb_seq;
  assign wb_addr   = r_wb_addr;
  assign wb_data   = r_wb_data;
  assign occupancy = r_occ;
  assign dup_err   = r_dup;
endmodule

// File: tb/tb_result_merger.sv
// Directed bench for result_merger (3-bit tags): reference reorder model
// compared every cycle, in-order scoreboard on writeback, literal spot checks.
module tb_result_merger;
  localparam int SW = 3, DW = 32, AW = 12, N = 1 << SW;

  logic          clk = 1'b0, resetn = 1'b0;
  logic          c1_valid, c1_ready, c2_valid, c2_ready;
  logic [SW-1:0] c1_seq, c2_seq, wb_seq;
  logic [AW-1:0] c1_addr, c2_addr, wb_addr;
  logic [DW-1:0] c1_data, c2_data, wb_data;
  logic          wb_valid, wb_ready, dup_err;
  logic [SW:0]   occupancy;

  always #5 clk = ~clk;

  result_merger #(.SEQ_W(SW), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .resetn(resetn),
    .c1_valid(c1_valid), .c1_ready(c1_ready), .c1_seq(c1_seq),
    .c1_addr(c1_addr), .c1_data(c1_data),
    .c2_valid(c2_valid), .c2_ready(c2_ready), .c2_seq(c2_seq),
    .c2_addr(c2_addr), .c2_data(c2_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_seq(wb_seq),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .occupancy(occupancy), .dup_err(dup_err));

  int n_chk = 0, n_pass = 0;
  task automatic chk(string nm, longint unsigned act, longint unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: a set of pending records keyed by tag, next tag to retire,
  // and the record currently offered to writeback.
  bit            mv[N];
  logic [AW-1:0] ma[N];
  logic [DW-1:0] md[N];
  int            mhead, mws;
  bit            mwv, mdup, armed = 0;
  logic [AW-1:0] mwa;
  logic [DW-1:0] mwd;
  int            exp_seq, n_wb, last_wb;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(mv[i]);
    return c;
  endfunction

  always @(posedge clk) begin
    bit a1, a2, cm;
    if (!resetn) begin
      for (int i = 0; i < N; i++) mv[i] = 0;
      mhead = 0; mwv = 0; mws = 0; mwa = '0; mwd = '0; mdup = 0;
      exp_seq = 0; armed = 1;
    end else begin
      a1 = c1_valid && !mv[c1_seq];
      a2 = c2_valid && !mv[c2_seq] && !(c1_valid && c1_seq == c2_seq);
      cm = mv[mhead] && (!mwv || wb_ready);
      if (cm) begin
        mws = mhead; mwa = ma[mhead]; mwd = md[mhead]; mwv = 1;
        mv[mhead] = 0; mhead = (mhead + 1) % N;
      end else if (mwv && wb_ready) mwv = 0;
      if (a1) begin mv[c1_seq] = 1; ma[c1_seq] = c1_addr; md[c1_seq] = c1_data; end
      if (a2) begin mv[c2_seq] = 1; ma[c2_seq] = c2_addr; md[c2_seq] = c2_data; end
      if (c1_valid && c2_valid && c1_seq == c2_seq) mdup = 1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("c1_ready", c1_ready, !mv[c1_seq]);
      chk("c2_ready", c2_ready, !mv[c2_seq] && !(c1_valid && c1_seq == c2_seq));
      chk("wb_valid", wb_valid, mwv);
      chk("wb_seq", wb_seq, mws);
      chk("wb_addr", wb_addr, mwa);
      chk("wb_data", wb_data, mwd);
      chk("occupancy", occupancy, m_count());
      chk("dup_err", dup_err, mdup);
      if (resetn && wb_valid && wb_ready) begin
        chk("order", wb_seq, exp_seq);
        exp_seq = (exp_seq + 1) % N;
        last_wb = int'(wb_seq);
        n_wb++;
      end
    end
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic idle(); c1_valid = 0; c2_valid = 0; endtask
  task automatic drv1(int t, int a, int d);
    c1_valid = 1; c1_seq = SW'(t); c1_addr = AW'(a); c1_data = DW'(d);
  endtask
  task automatic drv2(int t, int a, int d);
    c2_valid = 1; c2_seq = SW'(t); c2_addr = AW'(a); c2_data = DW'(d);
  endtask
  task automatic do_reset();
    resetn = 0; idle(); wb_ready = 1; step(); resetn = 1;
  endtask
  // Present one record on a core and hold it until accepted (bounded).
  task automatic send(int core, int t);
    bit got = 0;
    if (core == 1) drv1(t, 'h100 + t, 'hC100_0000 + t);
    else           drv2(t, 'h900 + t, 'hC200_0000 + t);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if ((core == 1) ? c1_ready : c2_ready) begin got = 1; break; end
    end
    if (!got) chk("send_timeout", 0, 1);
    step(); idle();
  endtask

  initial begin
    idle(); wb_ready = 1;
    c1_seq = '0; c2_seq = '0; c1_addr = '0; c2_addr = '0; c1_data = '0; c2_data = '0;
    step(); step(); resetn = 1;

    // In-order pair in one cycle
    drv1(0, 'h010, 'hA0); drv2(1, 'h811, 'hA1); step(); idle();
    @(negedge clk); chk("pair_wait", wb_valid, 0); chk("pair_occ2", occupancy, 2);
    step(); @(negedge clk);
    chk("pair_v0", wb_valid, 1); chk("pair_s0", wb_seq, 0); chk("pair_d0", wb_data, 'hA0);
    step(); @(negedge clk);
    chk("pair_s1", wb_seq, 1); chk("pair_a1", wb_addr, 'h811); chk("pair_d1", wb_data, 'hA1);
    step(); @(negedge clk); chk("pair_occ0", occupancy, 0); chk("pair_idle", wb_valid, 0);

    // Out of order: 2, 1, then 0
    do_reset();
    drv2(2, 'h22, 'hB2); step(); idle();
    drv1(1, 'h21, 'hB1); step(); idle();
    step();
    drv1(0, 'h20, 'hB0); step(); idle();
    @(negedge clk); chk("ooo_wait", wb_valid, 0); chk("ooo_occ", occupancy, 3);
    step(); @(negedge clk); chk("ooo_v", wb_valid, 1); chk("ooo_s0", wb_seq, 0);
    step(); @(negedge clk); chk("ooo_s1", wb_seq, 1);
    step(); @(negedge clk); chk("ooo_s2", wb_seq, 2); chk("ooo_d2", wb_data, 'hB2);
    step();

    // Backpressure
    do_reset(); wb_ready = 0;
    drv1(0, 'h30, 'hD0); step(); idle();
    step();
    drv1(1, 'h31, 'hD1); drv2(2, 'h32, 'hD2); step(); idle();
    drv1(3, 'h33, 'hD3); step(); idle();
    step(); step();
    @(negedge clk);
    chk("bp_hold_v", wb_valid, 1); chk("bp_hold_s", wb_seq, 0);
    chk("bp_hold_d", wb_data, 'hD0); chk("bp_occ3", occupancy, 3);
    step(); wb_ready = 1;
    @(negedge clk); chk("bp_s0", wb_seq, 0);
    step(); @(negedge clk); chk("bp_s1", wb_seq, 1);
    step(); @(negedge clk); chk("bp_s2", wb_seq, 2);
    step(); @(negedge clk); chk("bp_s3", wb_seq, 3); chk("bp_d3", wb_data, 'hD3);
    step(); @(negedge clk); chk("bp_drained", wb_valid, 0);

    // Wrap: 20 tags, alternating cores, random gaps
    do_reset(); n_wb = 0;
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 3)) step();
      send((k % 2) + 1, k % N);
    end
    repeat (4) step();
    @(negedge clk); chk("wrap_count", n_wb, 20); chk("wrap_last", last_wb, 3);

    // Alias stall on next-lap tag 1
    do_reset();
    for (int t = 1; t < N; t++) send((t % 2) + 1, t);
    drv1(1, 'h41, 'hE1);
    @(negedge clk); chk("alias_occ7", occupancy, 7); chk("alias_stall0", c1_ready, 0);
    step();
    drv2(0, 'h40, 'hE0); step(); c2_valid = 0;
    @(negedge clk); chk("alias_stall1", c1_ready, 0);
    step(); @(negedge clk); chk("alias_stall2", c1_ready, 0);
    step(); @(negedge clk); chk("alias_free", c1_ready, 1);
    step(); idle();
    @(negedge clk); chk("alias_nodup", dup_err, 0);
    repeat (8) step();

    // Duplicate tag, then reset with records pending
    do_reset();
    drv1(3, 'h53, 'hF3); drv2(3, 'h63, 'hF4);
    @(negedge clk); chk("dup_c1_rdy", c1_ready, 1); chk("dup_c2_rdy", c2_ready, 0);
    step(); idle();
    @(negedge clk); chk("dup_set", dup_err, 1); chk("dup_occ", occupancy, 1);
    wb_ready = 0;
    step(); drv1(0, 'h50, 'hF0); step(); idle(); step(); step();
    @(negedge clk); chk("dup_sticky", dup_err, 1); chk("dup_staged", wb_valid, 1);
    resetn = 0; step(); resetn = 1; wb_ready = 1;
    @(negedge clk);
    chk("rst_wbv", wb_valid, 0); chk("rst_occ", occupancy, 0);
    chk("rst_dup", dup_err, 0); chk("rst_seq", wb_seq, 0);
    drv1(0, 'h70, 'h77); step(); idle(); step();
    @(negedge clk); chk("rst_head0_v", wb_valid, 1); chk("rst_head0_d", wb_data, 'h77);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
